// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and helpers for the integer ALU divider
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    localparam int STEPS_1   = 1;
    localparam int STEPS_2   = 2;
    localparam int STEPS_4   = 4;
    localparam int ABS_MAX_W = 64;

    // Magnitude of the low `width` bits of val; callers truncate the result to their width.
    function automatic logic [ABS_MAX_W-1:0] abs_val(input logic [ABS_MAX_W-1:0] val,
                                                     input int                   width,
                                                     input logic                 is_signed);
        logic [ABS_MAX_W-1:0] res;
        res = val;
        if (is_signed && val[width-1]) begin
            res = ~val + {{(ABS_MAX_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift/subtract division step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0]   w_shift;
    logic             w_borrow;
    logic [WIDTH-1:0] w_diff;

    assign w_shift  = {i_rem, i_bit};
    // Borrow out of the WIDTH+1-bit subtract; when clear the difference fits in WIDTH bits.
    assign w_borrow = w_shift < {1'b0, i_divisor};
    assign w_diff   = w_shift[WIDTH-1:0] - i_divisor;
    assign o_q      = ~w_borrow;
    assign o_rem    = w_borrow ? w_shift[WIDTH-1:0] : w_diff;

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle signed/unsigned divider, STEPS quotient bits per cycle
module iter_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 1,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             start_i,
    output logic             ready_o,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             error_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int ITERS = WIDTH / STEPS;
    localparam int CNT_W = $clog2(ITERS + 1);

    if (!(STEPS == STEPS_1 || STEPS == STEPS_2 || STEPS == STEPS_4) ||
        (WIDTH % STEPS) != 0 || WIDTH < 8 || WIDTH > ABS_MAX_W) begin : g_bad_params
        $error("iter_divider: illegal WIDTH/STEPS combination");
    end

    div_state_t       r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem, r_quo, r_div;
    logic [WIDTH-1:0] r_quotient, r_remainder;
    logic             r_signed, r_sign_a, r_sign_b, r_error;
    logic [TAG_W-1:0] r_tag;

    logic             w_div_zero, w_ovf, w_special;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    logic [WIDTH-1:0] w_rem [STEPS+1];
    logic [WIDTH-1:0] w_quo [STEPS+1];
    logic             w_qbit [STEPS];

    assign w_div_zero = (divisor_i == '0);
    assign w_ovf      = signed_i && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor_i == '1);
    assign w_special  = w_div_zero || w_ovf;
    assign w_abs_a    = WIDTH'(abs_val(ABS_MAX_W'(dividend_i), WIDTH, signed_i));
    assign w_abs_b    = WIDTH'(abs_val(ABS_MAX_W'(divisor_i), WIDTH, signed_i));

    // r_quo doubles as the dividend shift register: dividend bits leave the top, quotient bits enter the bottom.
    assign w_rem[0] = r_rem;
    assign w_quo[0] = r_quo;
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .i_rem     (w_rem[gi]),
            .i_bit     (w_quo[gi][WIDTH-1]),
            .i_divisor (r_div),
            .o_rem     (w_rem[gi+1]),
            .o_q       (w_qbit[gi])
        );
        assign w_quo[gi+1] = {w_quo[gi][WIDTH-2:0], w_qbit[gi]};
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (r_state)
            IDLE:  begin
                ready_o = 1'b1;
                if (start_i) w_next = w_special ? DONE : CALC;
            end
            CALC:  if (r_cnt == CNT_W'(1)) w_next = FIXUP;
            FIXUP: w_next = DONE;
            DONE:  begin
                valid_o = 1'b1;
                if (ready_i) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (flush_i) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_signed    <= 1'b0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_error     <= 1'b0;
            r_tag       <= '0;
        end else if (flush_i) begin
            r_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start_i) begin
                    r_tag    <= tag_i;
                    r_signed <= signed_i;
                    r_sign_a <= signed_i & dividend_i[WIDTH-1];
                    r_sign_b <= signed_i & divisor_i[WIDTH-1];
                    r_rem    <= '0;
                    r_quo    <= w_abs_a;
                    r_div    <= w_abs_b;
                    r_cnt    <= CNT_W'(ITERS);
                    r_error  <= w_div_zero;
                    if (w_div_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= dividend_i;
                    end else if (w_ovf) begin
                        r_quotient  <= dividend_i;
                        r_remainder <= '0;
                    end
                end
                CALC: begin
                    r_rem <= w_rem[STEPS];
                    r_quo <= w_quo[STEPS];
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                FIXUP: begin
                    r_quotient  <= (r_signed && (r_sign_a ^ r_sign_b) && r_quo != '0) ? -r_quo : r_quo;
                    r_remainder <= (r_signed && r_sign_a && r_rem != '0) ? -r_rem : r_rem;
                end
                default: ;
            endcase
        end
    end

    assign quotient_o  = r_quotient;
    assign remainder_o = r_remainder;
    assign error_o     = r_error;
    assign tag_o       = r_tag;

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - randomized self-checking bench for iter_divider (STEPS=1 and STEPS=4)
module tb_iter_divider;

    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0, start = 1'b0;
    logic         sgn = 1'b0, rdy_i = 1'b0, sel = 1'b0;
    logic [W-1:0] dvd = '0, dvs = '0;
    logic [4:0]   tag = '0;

    logic         rdy1, val1, err1, rdy4, val4, err4;
    logic [W-1:0] q1, r1, q4, r4;
    logic [4:0]   tag1, tag4;
    logic         start1, start4, rdyi1, rdyi4;
    logic         c_ready, c_valid, c_err;
    logic [W-1:0] c_q, c_r;
    logic [4:0]   c_tag;

    int n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    assign start1  = start & ~sel;
    assign start4  = start & sel;
    assign rdyi1   = rdy_i & ~sel;
    assign rdyi4   = rdy_i & sel;
    assign c_ready = sel ? rdy4 : rdy1;
    assign c_valid = sel ? val4 : val1;
    assign c_err   = sel ? err4 : err1;
    assign c_q     = sel ? q4 : q1;
    assign c_r     = sel ? r4 : r1;
    assign c_tag   = sel ? tag4 : tag1;

    iter_divider #(.WIDTH(W), .STEPS(1), .TAG_W(5)) u_dut1 (
        .clk(clk), .rst_ni(rst_n), .flush_i(flush), .start_i(start1), .ready_o(rdy1),
        .signed_i(sgn), .dividend_i(dvd), .divisor_i(dvs), .tag_i(tag), .valid_o(val1),
        .ready_i(rdyi1), .quotient_o(q1), .remainder_o(r1), .error_o(err1), .tag_o(tag1)
    );

    iter_divider #(.WIDTH(W), .STEPS(4), .TAG_W(5)) u_dut4 (
        .clk(clk), .rst_ni(rst_n), .flush_i(flush), .start_i(start4), .ready_o(rdy4),
        .signed_i(sgn), .dividend_i(dvd), .divisor_i(dvs), .tag_i(tag), .valid_o(val4),
        .ready_i(rdyi4), .quotient_o(q4), .remainder_o(r4), .error_o(err4), .tag_o(tag4)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic e, output logic sp);
        e  = 1'b0;
        sp = 1'b0;
        if (b == 0) begin
            q = '1; r = a; e = 1'b1; sp = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0; sp = 1'b1;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Reference: one outstanding request; result visible m_lat edges after accept (accept edge counts as 1).
    logic         m_busy;
    int           m_cnt, m_lat;
    logic [W-1:0] m_q, m_r, t_q, t_r;
    logic         m_e, t_e, t_sp;
    logic [4:0]   m_tag;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (flush) begin
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                model(dvd, dvs, sgn, t_q, t_r, t_e, t_sp);
                m_q    <= t_q;
                m_r    <= t_r;
                m_e    <= t_e;
                m_tag  <= tag;
                m_lat  <= t_sp ? 1 : (sel ? W / 4 + 2 : W + 2);
                m_cnt  <= 1;
                m_busy <= 1'b1;
            end
        end else if (m_cnt >= m_lat && rdy_i) begin
            m_busy <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", c_ready, 1);
            chk("rst_valid", c_valid, 0);
            chk("rst_q", c_q, 0);
            chk("rst_r", c_r, 0);
            chk("rst_err", c_err, 0);
            chk("rst_tag", c_tag, 0);
        end else begin
            chk("ready", c_ready, !m_busy);
            chk("valid", c_valid, m_busy && m_cnt >= m_lat);
            if (c_valid && m_busy && m_cnt >= m_lat) begin
                chk("quotient", c_q, m_q);
                chk("remainder", c_r, m_r);
                chk("error", c_err, m_e);
                chk("tag", c_tag, m_tag);
            end
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        while (!c_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!c_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [4:0] tg);
        wait_ready();
        dvd = a; dvs = b; sgn = s; tag = tg; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [4:0] tg, input int hold,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic e,
                          output logic [4:0] tgo, output int lat);
        int t;
        issue(a, b, s, tg);
        lat = 1;
        t   = 0;
        while (!c_valid && t < 200) begin
            @(posedge clk); #1;
            lat++;
            t++;
        end
        if (!c_valid) chk("valid_timeout", 0, 1);
        q = c_q; r = c_r; e = c_err; tgo = c_tag;
        for (int k = 0; k < hold; k++) begin
            start = k[0];
            @(posedge clk); #1;
        end
        start = 1'b0;
        rdy_i = 1'b1;
        @(posedge clk); #1;
        rdy_i = 1'b0;
    endtask

    task automatic run_flush(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int n);
        issue(a, b, s, 5'h0A);
        repeat (n) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b0;
    endtask

    task automatic random_ops(input int n);
        logic [W-1:0] a, b, q, r;
        logic         e, s;
        logic [4:0]   tgo;
        int           lat;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       b = '1;
                2:       begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom; end
                3, 4:    b = $urandom_range(1, 15);
                5:       b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) run_flush(a, b, s, $urandom_range(0, 20));
            else run_op(a, b, s, 5'($urandom), $urandom_range(0, 3), q, r, e, tgo, lat);
        end
    endtask

    logic [W-1:0] q, r;
    logic         e;
    logic [4:0]   tgo;
    int           lat;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("init_ready", c_ready, 1);
        chk("init_valid", c_valid, 0);
        chk("init_q", c_q, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'd100, 32'd7, 1'b0, 5'h15, 0, q, r, e, tgo, lat);
        chk("u100_7_q", q, 14); chk("u100_7_r", r, 2); chk("u100_7_err", e, 0);
        chk("u100_7_lat", lat, 34); chk("u100_7_tag", tgo, 5'h15);

        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 5'h01, 0, q, r, e, tgo, lat);
        chk("sm7_2_q", q, 32'hFFFF_FFFD); chk("sm7_2_r", r, 32'hFFFF_FFFF);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 5'h02, 1, q, r, e, tgo, lat);
        chk("s7_m2_q", q, 32'hFFFF_FFFD); chk("s7_m2_r", r, 1);
        run_op(32'hFFFF_FFF8, 32'hFFFF_FFFE, 1'b1, 5'h03, 0, q, r, e, tgo, lat);
        chk("sm8_m2_q", q, 4); chk("sm8_m2_r", r, 0);

        for (int m = 0; m < 2; m++) begin
            run_op(32'h1234, 32'h0, 1'(m), 5'h04, 0, q, r, e, tgo, lat);
            chk("dz_q", q, 32'hFFFF_FFFF); chk("dz_r", r, 32'h1234);
            chk("dz_err", e, 1); chk("dz_lat", lat, 1);
        end

        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'h05, 0, q, r, e, tgo, lat);
        chk("ovf_q", q, 32'h8000_0000); chk("ovf_r", r, 0); chk("ovf_err", e, 0); chk("ovf_lat", lat, 1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'h06, 0, q, r, e, tgo, lat);
        chk("uovf_q", q, 0); chk("uovf_r", r, 32'h8000_0000); chk("uovf_lat", lat, 34);

        run_op(32'd100, 32'd7, 1'b0, 5'h07, 10, q, r, e, tgo, lat);
        chk("hold_q", q, 14);
        chk("hold_reaccept_ready", c_ready, 1);

        run_flush(32'd1000, 32'd3, 1'b0, 5);
        chk("flush_ready", c_ready, 1);
        chk("flush_valid", c_valid, 0);

        issue(32'd1000, 32'd3, 1'b0, 5'h08);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_ready", c_ready, 1); chk("arst_valid", c_valid, 0);
        chk("arst_q", c_q, 0); chk("arst_r", c_r, 0); chk("arst_tag", c_tag, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(32'd1000, 32'd3, 1'b0, 5'h09, 0, q, r, e, tgo, lat);
        chk("post_rst_q", q, 333); chk("post_rst_r", r, 1); chk("post_rst_lat", lat, 34);

        random_ops(60);

        sel = 1'b1;
        @(posedge clk); #1;
        run_op(32'hFFFF_FFFF, 32'd3, 1'b0, 5'h0B, 0, q, r, e, tgo, lat);
        chk("s4_q", q, 32'h5555_5555); chk("s4_r", r, 0); chk("s4_lat", lat, 10);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 5'h0C, 0, q, r, e, tgo, lat);
        chk("s4_sm7_2_q", q, 32'hFFFF_FFFD); chk("s4_sm7_2_r", r, 32'hFFFF_FFFF);

        random_ops(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
